spiker_feeder: RTL and testbench
================================

SPIKER_FEEDER -- requirements
Module: spiker_feeder

Interface
- REQ-001: Parameter WIDTH, default 32, width of one register word.
- REQ-002: Parameter N_SPIKES, default 784, number of input spikes per image.
- REQ-003: Parameter N_WORDS, default 25, words per image, equal to ceil(N_SPIKES/WIDTH).
- REQ-004: Parameter N_STEPS, default 15, core time steps per image.
- REQ-005: Port clk_i, input, 1, clock; all logic on the rising edge.
- REQ-006: Port rst_ni, input, 1, reset; asynchronous, active-low.
- REQ-007: Port word_i, input, WIDTH, spike word from the register file.
- REQ-008: Port word_valid_i, input, 1, word_i valid.
- REQ-009: Port word_ready_o, output, 1, feeder accepts word_i.
- REQ-010: Port start_i, input, 1, single-cycle start-inference command.
- REQ-011: Port clear_i, input, 1, synchronous abort.
- REQ-012: Port core_ready_i, input, 1, level; core can take a step.
- REQ-013: Port writer_ready_i, input, 1, level; downstream writer can capture a result.
- REQ-014: Port data_in_o, output, N_SPIKES, spike vector to the core.
- REQ-015: Port sample_o, output, 1, one-cycle step strobe to core and writer.
- REQ-016: Port busy_o, output, 1, high in STEP and WAIT.
- REQ-017: Port done_o, output, 1, one-cycle pulse after the final step.

Function
- REQ-018: FSM states SHALL be LOAD, ARMED, STEP, WAIT and DONE; the reset state is LOAD.
- REQ-019: word_ready_o SHALL equal 1 only in LOAD.
- REQ-020: A word is accepted when word_valid_i and word_ready_o are both 1; word k (0-based) is stored to buffer bits [k*WIDTH +: WIDTH].
- REQ-021: Bits of word N_WORDS-1 above N_SPIKES SHALL be discarded; for the defaults, word 24 bits [31:16] are dropped.
- REQ-022: Accepting word N_WORDS-1 SHALL move LOAD to ARMED and reset word_idx to 0.
- REQ-023: In ARMED, start_i SHALL latch the buffer into data_in_o, clear step_cnt and move to STEP in the next cycle.
- REQ-024: start_i outside ARMED SHALL be ignored.
- REQ-025: In STEP, when core_ready_i and writer_ready_i are both 1, sample_o SHALL be 1 for exactly that cycle, step_cnt SHALL increment and the FSM SHALL move to WAIT.
- REQ-026: In STEP, if either ready input is 0, sample_o SHALL be 0 and the FSM SHALL hold.
- REQ-027: WAIT lasts exactly one cycle and ignores both ready inputs; it moves to DONE when step_cnt equals N_STEPS, otherwise to STEP.
- REQ-028: Consecutive sample_o pulses SHALL therefore be at least 2 cycles apart.
- REQ-029: done_o SHALL be 1 only in DONE, which lasts 1 cycle.
- REQ-030: data_in_o SHALL stay stable from the start_i latch until the next latch or clear.
- REQ-031: clear_i SHALL take priority over every other event in the same cycle:
  - go to LOAD;
  - word_idx and step_cnt to 0;
  - data_in_o to 0;
  - no word is accepted that cycle;
  - no sample_o that cycle.
- REQ-032: step_cnt SHALL be sized as $clog2(N_STEPS+1) bits and SHALL never wrap.

Reset
- REQ-033: While rst_ni is 0, outputs SHALL be:
  - data_in_o = 0, sample_o = 0, done_o = 0, busy_o = 0;
  - word_ready_o = 1;
  - state = LOAD, word_idx = 0, step_cnt = 0, buffer = 0.
- REQ-034: Reset asserted mid-load or mid-run SHALL discard all progress, with no sample_o or done_o pulse afterwards.

Configuration
- REQ-035: With macro SPIKER_FEEDER_REPLAY_EN defined, DONE SHALL go to ARMED and keep the buffer, so start_i reruns the same image without reloading.
- REQ-036: Without SPIKER_FEEDER_REPLAY_EN, DONE SHALL go to LOAD and a new image of N_WORDS words is required.

Structure
- REQ-037: The constants WIDTH, N_SPIKES, N_WORDS and N_STEPS, and the enum feeder_state_e, SHALL live in package spiker_adapter_pkg.
- REQ-038: The word buffer and word_idx SHALL be implemented in sub-module spiker_feeder_buf, which exposes word write, a full flag and clear.

Verification
- REQ-039: Load 25 words 0x00000001..0x00000019, then start_i with both ready inputs held at 1 -> data_in_o[31:0]=0x1, data_in_o[783:768]=0x0019, 15 sample_o pulses 2 cycles apart, then done_o for 1 cycle.
- REQ-040: Word 24 = 0xFFFF_ABCD -> data_in_o[783:768]=0xABCD and no bit beyond index 783 exists.
- REQ-041: writer_ready_i=0 for 10 cycles during step 3 -> no sample_o in that window; the step fires on the first cycle both ready inputs are 1; the total is still 15 pulses.
- REQ-042: start_i pulsed during LOAD after 12 words, and again during STEP -> both ignored; the count reaches exactly 15.
- REQ-043: clear_i asserted in the same cycle as the 25th accepted word -> state LOAD, word_idx 0, no ARMED; a following full load behaves normally.
- REQ-044: Two runs, compiled with and then without SPIKER_FEEDER_REPLAY_EN:
  - with the macro, a second start_i after done_o gives 15 more pulses with identical data_in_o;
  - without it, word_ready_o=1 after done_o and start_i is ignored.

Source files
------------

// File: rtl/spiker_adapter_pkg.sv
// rtl/spiker_adapter_pkg.sv - shared constants and FSM encoding for the spike feeder
package spiker_adapter_pkg;

  localparam int WIDTH    = 32;
  localparam int N_SPIKES = 784;
  localparam int N_WORDS  = (N_SPIKES + WIDTH - 1) / WIDTH;
  localparam int N_STEPS  = 15;

  typedef enum logic [2:0] {
    LOAD,
    ARMED,
    STEP,
    WAIT,
    DONE
  } feeder_state_e;

endpackage

// File: rtl/spiker_feeder_buf.sv
// rtl/spiker_feeder_buf.sv - image word buffer with write pointer, full flag and clear
// Word k lands in bits [k*WIDTH +: WIDTH]; bits of the last word beyond N_SPIKES are never stored.
module spiker_feeder_buf #(
  parameter int WIDTH    = spiker_adapter_pkg::WIDTH,
  parameter int N_SPIKES = spiker_adapter_pkg::N_SPIKES,
  parameter int N_WORDS  = spiker_adapter_pkg::N_WORDS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                wr_en_i,
  input  logic [WIDTH-1:0]    word_i,
  output logic                full_o,
  output logic [N_SPIKES-1:0] buf_o
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  logic [IDX_W-1:0] word_idx_d, word_idx_q;

  // Asserted on the write that completes the image.
  assign full_o = wr_en_i && (word_idx_q == LAST_IDX);

  always_comb begin
    word_idx_d = word_idx_q;
    if (clear_i) begin
      word_idx_d = '0;
    end else if (wr_en_i) begin
      word_idx_d = full_o ? '0 : word_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_idx_q <= '0;
    end else begin
      word_idx_q <= word_idx_d;
    end
  end

  for (genvar k = 0; k < N_WORDS; k++) begin : g_word
    localparam int LO    = k * WIDTH;
    localparam int HI    = ((k + 1) * WIDTH <= N_SPIKES) ? (k + 1) * WIDTH - 1 : N_SPIKES - 1;
    localparam int SEG_W = HI - LO + 1;
    localparam logic [IDX_W-1:0] K_IDX = IDX_W'(k);

    logic [SEG_W-1:0] seg_d, seg_q;

    always_comb begin
      seg_d = seg_q;
      if (clear_i) begin
        seg_d = '0;
      end else if (wr_en_i && (word_idx_q == K_IDX)) begin
        seg_d = word_i[SEG_W-1:0];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        seg_q <= '0;
      end else begin
        seg_q <= seg_d;
      end
    end

    assign buf_o[HI:LO] = seg_q;
  end

endmodule

// File: rtl/spiker_feeder.sv
// rtl/spiker_feeder.sv - loads a spike image word by word and steps the core N_STEPS times
// SPIKER_FEEDER_REPLAY_EN: DONE returns to ARMED and keeps the image for another start.
module spiker_feeder #(
  parameter int WIDTH    = spiker_adapter_pkg::WIDTH,
  parameter int N_SPIKES = spiker_adapter_pkg::N_SPIKES,
  parameter int N_WORDS  = spiker_adapter_pkg::N_WORDS,
  parameter int N_STEPS  = spiker_adapter_pkg::N_STEPS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [WIDTH-1:0]    word_i,
  input  logic                word_valid_i,
  output logic                word_ready_o,
  input  logic                start_i,
  input  logic                clear_i,
  input  logic                core_ready_i,
  input  logic                writer_ready_i,
  output logic [N_SPIKES-1:0] data_in_o,
  output logic                sample_o,
  output logic                busy_o,
  output logic                done_o
);

  import spiker_adapter_pkg::*;

  localparam int CNT_W = $clog2(N_STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS);

  feeder_state_e       state_d, state_q;
  logic [CNT_W-1:0]    step_cnt_d, step_cnt_q;
  logic [N_SPIKES-1:0] data_d, data_q;
  logic [N_SPIKES-1:0] buf_data;
  logic                wr_en;
  logic                buf_full;
  logic                fire;

  assign word_ready_o = (state_q == LOAD);
  assign wr_en        = word_valid_i && word_ready_o && !clear_i;
  assign fire         = (state_q == STEP) && core_ready_i && writer_ready_i && !clear_i;
  assign sample_o     = fire;
  assign busy_o       = (state_q == STEP) || (state_q == WAIT);
  assign done_o       = (state_q == DONE);
  assign data_in_o    = data_q;

  spiker_feeder_buf #(
    .WIDTH   (WIDTH),
    .N_SPIKES(N_SPIKES),
    .N_WORDS (N_WORDS)
  ) u_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .wr_en_i(wr_en),
    .word_i (word_i),
    .full_o (buf_full),
    .buf_o  (buf_data)
  );

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    data_d     = data_q;
    if (clear_i) begin
      state_d    = LOAD;
      step_cnt_d = '0;
      data_d     = '0;
    end else begin
      case (state_q)
        LOAD:  if (buf_full) state_d = ARMED;
        ARMED: begin
          if (start_i) begin
            data_d     = buf_data;
            step_cnt_d = '0;
            state_d    = STEP;
          end
        end
        STEP: begin
          if (fire) begin
            step_cnt_d = step_cnt_q + 1'b1;
            state_d    = WAIT;
          end
        end
        // Exits at N_STEPS, so step_cnt never wraps.
        WAIT:  state_d = (step_cnt_q == LAST_STEP) ? DONE : STEP;
`ifdef SPIKER_FEEDER_REPLAY_EN
        DONE:  state_d = ARMED;
`else
        DONE:  state_d = LOAD;
`endif
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LOAD;
      step_cnt_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_spiker_feeder.sv
// tb/tb_spiker_feeder.sv - directed self-checking bench for spiker_feeder
`timescale 1ns/1ps
module tb_spiker_feeder;

  localparam int WIDTH    = 32;
  localparam int N_SPIKES = 784;
  localparam int N_WORDS  = 25;
  localparam int N_STEPS  = 15;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [WIDTH-1:0]    word_i = '0;
  logic                word_valid_i = 1'b0;
  logic                word_ready_o;
  logic                start_i = 1'b0;
  logic                clear_i = 1'b0;
  logic                core_ready_i = 1'b1;
  logic                writer_ready_i = 1'b1;
  logic [N_SPIKES-1:0] data_in_o;
  logic                sample_o;
  logic                busy_o;
  logic                done_o;

  always #5 clk_i = ~clk_i;

  spiker_feeder dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .word_i        (word_i),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .start_i       (start_i),
    .clear_i       (clear_i),
    .core_ready_i  (core_ready_i),
    .writer_ready_i(writer_ready_i),
    .data_in_o     (data_in_o),
    .sample_o      (sample_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int sample_cnt = 0;
  int done_cnt   = 0;
  int gap2_cnt   = 0;
  int short_gaps = 0;
  int last_sample = -100;
  always @(negedge clk_i) begin
    if (sample_o) begin
      if (cyc - last_sample == 2) gap2_cnt++;
      if (cyc - last_sample < 2) short_gaps++;
      last_sample = cyc;
      sample_cnt++;
    end
    if (done_o) done_cnt++;
  end

  logic [WIDTH-1:0] img [N_WORDS];

  function automatic logic [N_SPIKES-1:0] exp_vec();
    logic [N_WORDS*WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < N_WORDS; k++) w[k*WIDTH +: WIDTH] = img[k];
    return w[N_SPIKES-1:0];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; word_valid_i = 1'b0; word_i = '0; start_i = 1'b0; clear_i = 1'b0;
    core_ready_i = 1'b1; writer_ready_i = 1'b1;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic load_words(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      word_i = img[k]; word_valid_i = 1'b1;
      tick();
    end
    word_valid_i = 1'b0; word_i = '0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (done_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_samples(input int base, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i);
      if (sample_cnt - base >= n) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; word_valid_i = 1'b1; word_i = 32'hDEAD_BEEF; start_i = 1'b1;
    tick(); tick();
    checks++; if (word_ready_o !== 1'b1) begin errors++; $display("FAIL reset_word_ready: got %b expected 1", word_ready_o); end
    checks++; if ({busy_o, done_o, sample_o} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got busy/done/sample %b expected 000", {busy_o, done_o, sample_o}); end
    checks++; if (data_in_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_in_o); end
    word_valid_i = 1'b0; start_i = 1'b0; word_i = '0;
    rst_ni = 1'b1;
    tick();
    checks++; if (word_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_load: got ready %b busy %b expected 1 0", word_ready_o, busy_o); end
  endtask

  task automatic test_basic();
    int s0, g0, d0;
    bit ok;
    do_reset();
    for (int k = 0; k < N_WORDS; k++) img[k] = 32'(k + 1);
    load_words(0, N_WORDS - 1);
    checks++; if (word_ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL basic_armed: got ready %b busy %b expected 0 0", word_ready_o, busy_o); end
    s0 = sample_cnt; g0 = gap2_cnt; d0 = done_cnt;
    pulse_start();
    checks++; if (data_in_o[31:0] !== 32'h1) begin errors++; $display("FAIL basic_word0: got %h expected 00000001", data_in_o[31:0]); end
    checks++; if (data_in_o[783:768] !== 16'h0019) begin errors++; $display("FAIL basic_word24: got %h expected 0019", data_in_o[783:768]); end
    checks++; if (data_in_o !== exp_vec()) begin errors++; $display("FAIL basic_vector: got %h expected %h", data_in_o, exp_vec()); end
    @(negedge clk_i);
    checks++; if (sample_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL basic_first_step: got sample %b busy %b expected 1 1", sample_o, busy_o); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done_o expected done_o within 200 cycles"); end
    tick();
    checks++; if (sample_cnt - s0 !== 15) begin errors++; $display("FAIL basic_pulses: got %0d expected 15", sample_cnt - s0); end
    checks++; if (gap2_cnt - g0 !== 14) begin errors++; $display("FAIL basic_gap2: got %0d expected 14", gap2_cnt - g0); end
    checks++; if (done_cnt - d0 !== 1 || done_o !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %0d cycles expected 1", done_cnt - d0); end
  endtask

  task automatic test_width();
    bit ok;
    do_reset();
    for (int k = 0; k < N_WORDS; k++) img[k] = 32'hA5A5_0000 | 32'(k);
    img[24] = 32'hFFFF_ABCD;
    load_words(0, N_WORDS - 1);
    pulse_start();
    checks++; if (data_in_o[783:768] !== 16'hABCD) begin errors++; $display("FAIL width_top: got %h expected abcd", data_in_o[783:768]); end
    checks++; if (data_in_o[767:736] !== 32'hA5A5_0017) begin errors++; $display("FAIL width_word23: got %h expected a5a50017", data_in_o[767:736]); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL width_done_timeout: got no done_o expected done_o within 200 cycles"); end
    tick();
  endtask

  task automatic test_stall();
    int s0, stalled;
    bit ok;
    do_reset();
    for (int k = 0; k < N_WORDS; k++) img[k] = 32'h0F0F_0000 + 32'(k * 7);
    load_words(0, N_WORDS - 1);
    s0 = sample_cnt;
    pulse_start();
    wait_samples(s0, 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_reach_step3: got %0d pulses expected 2", sample_cnt - s0); end
    writer_ready_i = 1'b0;
    stalled = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (sample_o) stalled++;
    end
    checks++; if (stalled !== 0) begin errors++; $display("FAIL stall_window: got %0d pulses expected 0", stalled); end
    @(posedge clk_i); #1;
    writer_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (sample_o !== 1'b1) begin errors++; $display("FAIL stall_resume: got %b expected 1", sample_o); end
    wait_done(ok);
    tick();
    checks++; if (!ok || sample_cnt - s0 !== 15) begin errors++; $display("FAIL stall_total: got %0d expected 15", sample_cnt - s0); end
  endtask

  task automatic test_start_ignored();
    int s0;
    bit ok;
    do_reset();
    for (int k = 0; k < N_WORDS; k++) img[k] = 32'h1000_0000 + 32'(k * 3);
    load_words(0, 11);
    pulse_start();
    checks++; if (word_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL start_in_load: got ready %b busy %b expected 1 0", word_ready_o, busy_o); end
    load_words(12, N_WORDS - 1);
    checks++; if (word_ready_o !== 1'b0) begin errors++; $display("FAIL start_load_armed: got ready %b expected 0", word_ready_o); end
    s0 = sample_cnt;
    pulse_start();
    checks++; if (data_in_o !== exp_vec()) begin errors++; $display("FAIL start_load_vector: got %h expected %h", data_in_o, exp_vec()); end
    wait_samples(s0, 3, ok);
    tick();
    pulse_start();
    wait_done(ok);
    tick();
    checks++; if (!ok || sample_cnt - s0 !== 15) begin errors++; $display("FAIL start_in_step_total: got %0d expected 15", sample_cnt - s0); end
  endtask

  task automatic test_clear();
    int s0, s1, d1;
    bit ok;
    do_reset();
    for (int k = 0; k < N_WORDS; k++) img[k] = 32'h0101_0101 * 32'(k) + 32'h7;
    load_words(0, N_WORDS - 2);
    word_i = img[24]; word_valid_i = 1'b1; clear_i = 1'b1;
    tick();
    word_valid_i = 1'b0; clear_i = 1'b0;
    checks++; if (word_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL clear_last_word: got ready %b busy %b expected 1 0", word_ready_o, busy_o); end
    for (int k = 0; k < N_WORDS; k++) img[k] = 32'hC000_0000 ^ 32'(k * 11);
    load_words(0, N_WORDS - 2);
    checks++; if (word_ready_o !== 1'b1) begin errors++; $display("FAIL clear_idx_reset: got ready %b expected 1", word_ready_o); end
    load_words(N_WORDS - 1, N_WORDS - 1);
    checks++; if (word_ready_o !== 1'b0) begin errors++; $display("FAIL clear_reload_armed: got ready %b expected 0", word_ready_o); end
    s0 = sample_cnt;
    pulse_start();
    checks++; if (data_in_o !== exp_vec()) begin errors++; $display("FAIL clear_reload_vector: got %h expected %h", data_in_o, exp_vec()); end
    wait_samples(s0, 4, ok);
    tick();
    clear_i = 1'b1;
    @(negedge clk_i);
    checks++; if (sample_o !== 1'b0) begin errors++; $display("FAIL clear_no_sample: got %b expected 0", sample_o); end
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    checks++; if (data_in_o !== '0 || word_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL clear_run_state: got ready %b busy %b data_zero %b expected 1 0 1", word_ready_o, busy_o, data_in_o == '0); end
    s1 = sample_cnt; d1 = done_cnt;
    for (int i = 0; i < 40; i++) tick();
    checks++; if (sample_cnt - s1 !== 0 || done_cnt - d1 !== 0) begin errors++; $display("FAIL clear_quiet: got %0d pulses %0d done expected 0 0", sample_cnt - s1, done_cnt - d1); end
  endtask

  task automatic test_reset_midrun();
    int s0, s1, d1;
    bit ok;
    do_reset();
    for (int k = 0; k < N_WORDS; k++) img[k] = 32'h5555_0000 | 32'(k);
    load_words(0, N_WORDS - 1);
    s0 = sample_cnt;
    pulse_start();
    wait_samples(s0, 2, ok);
    rst_ni = 1'b0;
    #1;
    checks++; if (data_in_o !== '0 || word_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL async_reset: got ready %b busy %b data_zero %b expected 1 0 1", word_ready_o, busy_o, data_in_o == '0); end
    tick();
    rst_ni = 1'b1;
    s1 = sample_cnt; d1 = done_cnt;
    for (int i = 0; i < 40; i++) tick();
    checks++; if (sample_cnt - s1 !== 0 || done_cnt - d1 !== 0) begin errors++; $display("FAIL reset_quiet: got %0d pulses %0d done expected 0 0", sample_cnt - s1, done_cnt - d1); end
  endtask

  task automatic test_replay();
    int s0;
    bit ok;
    logic [N_SPIKES-1:0] d1;
    do_reset();
    for (int k = 0; k < N_WORDS; k++) img[k] = 32'h3C3C_0000 + 32'(k * 5);
    load_words(0, N_WORDS - 1);
    pulse_start();
    d1 = data_in_o;
    wait_done(ok);
    tick();
    s0 = sample_cnt;
`ifdef SPIKER_FEEDER_REPLAY_EN
    checks++; if (word_ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL replay_armed: got ready %b busy %b expected 0 0", word_ready_o, busy_o); end
    pulse_start();
    checks++; if (data_in_o !== d1 || d1 !== exp_vec()) begin errors++; $display("FAIL replay_data: got %h expected %h", data_in_o, exp_vec()); end
    wait_done(ok);
    tick();
    checks++; if (!ok || sample_cnt - s0 !== 15) begin errors++; $display("FAIL replay_pulses: got %0d expected 15", sample_cnt - s0); end
`else
    checks++; if (word_ready_o !== 1'b1) begin errors++; $display("FAIL noreplay_load: got ready %b expected 1", word_ready_o); end
    pulse_start();
    for (int i = 0; i < 40; i++) tick();
    checks++; if (sample_cnt - s0 !== 0 || busy_o !== 1'b0 || data_in_o !== d1) begin errors++; $display("FAIL noreplay_start_ignored: got %0d pulses busy %b expected 0 0", sample_cnt - s0, busy_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width();
    test_stall();
    test_start_ignored();
    test_clear();
    test_reset_midrun();
    test_replay();
    checks++; if (short_gaps !== 0) begin errors++; $display("FAIL pulse_spacing: got %0d short gaps expected 0", short_gaps); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish before 500000 ns");
    $fatal(1, "watchdog");
  end

endmodule
